// File: rtl/pwm_capture_pkg.sv
// Shared definitions for the PWM capture path: FSM state encoding and the
// default counter width that the PWM driver also uses.
package pwm_capture_pkg;

  localparam int unsigned PWM_CNT_W = 24;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HIGH = 2'd1,
    ST_LOW  = 2'd2
  } state_e;

endpackage

// File: rtl/sync_edge.sv
// Multi-flop synchronizer for an asynchronous pin, followed by a previous-value
// flop that provides single-cycle rise/fall strobes.
module sync_edge #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic async_i,
  output logic sync_o,
  output logic rise_o,
  output logic fall_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], async_i};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign sync_o = sync_q[SYNC_STAGES-1];
  assign rise_o = sync_o & ~prev_q;
  assign fall_o = ~sync_o & prev_q;

endmodule

// File: rtl/pwm_capture.sv
// Measures high time and period of an asynchronous PWM input in clk cycles,
// flagging a stuck input when no full period arrives within counter range.
module pwm_capture
  import pwm_capture_pkg::*;
#(
  parameter int unsigned CNT_W       = PWM_CNT_W,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             pwm_in,
  output logic [CNT_W-1:0] high_cnt,
  output logic [CNT_W-1:0] period_cnt,
  output logic             valid,
  output logic             stuck,
  output logic             stuck_level
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic sync, rise, fall;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] hi_lat_q, hi_lat_d;
  logic [CNT_W-1:0] high_q, high_d;
  logic [CNT_W-1:0] period_q, period_d;
  logic             valid_q, valid_d;
  logic             stuck_q, stuck_d;
  logic             stuck_lvl_q, stuck_lvl_d;

  logic             sat;
  logic [CNT_W-1:0] cnt_inc;

  sync_edge #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync_edge (
    .clk    (clk),
    .rst_n  (rst_n),
    .async_i(pwm_in),
    .sync_o (sync),
    .rise_o (rise),
    .fall_o (fall)
  );

  // Holding at CNT_MAX (rather than wrapping) lets a fall on the saturating
  // cycle still reach LOW, where the next cycle then flags stuck.
  assign sat     = (cnt_q == CNT_MAX);
  assign cnt_inc = sat ? cnt_q : cnt_q + CNT_ONE;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (rise) state_d = ST_HIGH;
      ST_HIGH: begin
        if (fall)     state_d = ST_LOW;
        else if (sat) state_d = ST_IDLE;
      end
      ST_LOW: begin
        if (rise)     state_d = ST_HIGH;
        else if (sat) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // An edge takes priority over saturation in the same cycle.
  always_comb begin
    cnt_d       = cnt_q;
    hi_lat_d    = hi_lat_q;
    high_d      = high_q;
    period_d    = period_q;
    valid_d     = 1'b0;
    stuck_d     = stuck_q;
    stuck_lvl_d = stuck_lvl_q;
    unique case (state_q)
      ST_IDLE: begin
        if (rise) begin
          cnt_d   = CNT_ONE;
          stuck_d = 1'b0;
        end
      end
      ST_HIGH: begin
        if (fall) begin
          hi_lat_d = cnt_q;
          cnt_d    = cnt_inc;
        end else if (sat) begin
          stuck_d     = 1'b1;
          stuck_lvl_d = sync;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      ST_LOW: begin
        if (rise) begin
          period_d = cnt_q;
          high_d   = hi_lat_q;
          valid_d  = 1'b1;
          cnt_d    = CNT_ONE;
        end else if (sat) begin
          stuck_d     = 1'b1;
          stuck_lvl_d = sync;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q       <= '0;
      hi_lat_q    <= '0;
      high_q      <= '0;
      period_q    <= '0;
      valid_q     <= 1'b0;
      stuck_q     <= 1'b0;
      stuck_lvl_q <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      hi_lat_q    <= hi_lat_d;
      high_q      <= high_d;
      period_q    <= period_d;
      valid_q     <= valid_d;
      stuck_q     <= stuck_d;
      stuck_lvl_q <= stuck_lvl_d;
    end
  end

  assign high_cnt    = high_q;
  assign period_cnt  = period_q;
  assign valid       = valid_q;
  assign stuck       = stuck_q;
  assign stuck_level = stuck_lvl_q;

endmodule
